// File: rtl/fetch_queue_pkg.sv
// Shared constants for the instruction fetch front end: default widths, reset PC,
// the NOP presented on an empty fetch slot, and the instruction size in bytes.
package fetch_queue_pkg;

    localparam int          DEF_XLEN     = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam int          INSTR_BYTES  = 4;

    // Counter width able to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch queue, instruction memory and the IF/ID register.
// master = fetch queue side, slave = memory/decode side.
interface fetch_queue_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instruction;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output if_valid, if_pc, if_instruction,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  if_valid, if_pc, if_instruction,
        output if_ready
    );

endinterface

// File: rtl/fetch_queue_chk.sv
// Invariant checker for the fetch queue: credit accounting never over-commits
// the buffer and a response is never pushed into a full FIFO.
module fetch_queue_chk #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             reset,
    input logic             push,
    input logic             full,
    input logic [CNT_W-1:0] count,
    input logic [CNT_W-1:0] inflight
);

    localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

    logic [CNT_W:0] occupancy_s;

    assign occupancy_s = {1'b0, count} + {1'b0, inflight};

    a_no_push_when_full : assert property (@(posedge clk) disable iff (!reset) !(push && full));
    a_credit_bound      : assert property (@(posedge clk) disable iff (!reset) occupancy_s <= DEPTH_OCC);

endmodule

// File: rtl/fetch_queue_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with push/pop and a clear that beats both.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             write_s;
    logic             read_s;

    // Next-state for pointers, occupancy and storage.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        write_s  = push && !full;
        read_s   = pop && !empty;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (write_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (read_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(write_s) - CNT_W'(read_s);
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage needs no reset; occupancy decides what is visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, issues credit-limited word requests, buffers responses
// for IF/ID and drops stale responses after a redirect. Optional macro FETCH_BYPASS_EN.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    fetch_queue_if.master   bus
);

    localparam int              CNT_W     = cnt_width(DEPTH);
    localparam logic [CNT_W:0]  DEPTH_OCC = (CNT_W + 1)'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] NOP_WORD  = XLEN'(NOP_INSTR);

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  pending_drop_q, pending_drop_d;

    logic [CNT_W-1:0]  count_s;
    logic              full_s;
    logic              empty_s;
    logic [2*XLEN-1:0] head_s;
    logic [CNT_W:0]    occupancy_s;
    logic [XLEN-1:0]   redirect_target_s;
    logic              req_valid_s;
    logic              req_fire_s;
    logic              resp_keep_s;
    logic              bypass_s;
    logic              if_valid_s;
    logic              push_s;
    logic              pop_s;

    // Issue credit, response acceptance and IF-side handshake decode.
    always_comb begin
        redirect_target_s = {redirect_pc[XLEN-1:2], 2'b00};
        occupancy_s       = {1'b0, count_s} + {1'b0, inflight_q};
        req_valid_s       = reset && !redirect_valid && (occupancy_s < DEPTH_OCC);
        req_fire_s        = req_valid_s && bus.imem_req_ready;
        resp_keep_s       = bus.imem_resp_valid && !redirect_valid && (pending_drop_q == '0);
`ifdef FETCH_BYPASS_EN
        bypass_s          = resp_keep_s && empty_s;
`else
        bypass_s          = 1'b0;
`endif
        if_valid_s        = !empty_s || bypass_s;
        pop_s             = !empty_s && bus.if_ready;
        // A bypassed word that decode takes immediately never enters the FIFO.
        push_s            = resp_keep_s && !(bypass_s && bus.if_ready);
    end

    // PC, in-flight and drop bookkeeping; a redirect overrides everything else.
    always_comb begin
        fetch_pc_d     = fetch_pc_q;
        resp_pc_d      = resp_pc_q;
        pending_drop_d = pending_drop_q;
        inflight_d     = inflight_q + CNT_W'(req_fire_s) - CNT_W'(bus.imem_resp_valid);
        if (redirect_valid) begin
            fetch_pc_d     = redirect_target_s;
            resp_pc_d      = redirect_target_s;
            pending_drop_d = inflight_q - CNT_W'(bus.imem_resp_valid);
        end else begin
            if (req_fire_s) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (resp_keep_s) begin
                resp_pc_d = resp_pc_q + PC_STEP;
            end else begin
                resp_pc_d = resp_pc_q;
            end
            if (bus.imem_resp_valid && (pending_drop_q != '0)) begin
                pending_drop_d = pending_drop_q - CNT_W'(1'b1);
            end else begin
                pending_drop_d = pending_drop_q;
            end
        end
    end

    // Fetch state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q     <= RESET_PC;
            resp_pc_q      <= RESET_PC;
            inflight_q     <= '0;
            pending_drop_q <= '0;
        end else begin
            fetch_pc_q     <= fetch_pc_d;
            resp_pc_q      <= resp_pc_d;
            inflight_q     <= inflight_d;
            pending_drop_q <= pending_drop_d;
        end
    end

    fetch_queue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (push_s),
        .push_data ({resp_pc_q, bus.imem_resp_data}),
        .pop       (pop_s),
        .head_data (head_s),
        .count     (count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    fetch_queue_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk      (clk),
        .reset    (reset),
        .push     (push_s),
        .full     (full_s),
        .count    (count_s),
        .inflight (inflight_q)
    );

    // IF/ID outputs: FIFO head, the bypassed response, or the empty-slot NOP.
    always_comb begin
        bus.imem_req_valid = req_valid_s;
        bus.imem_req_addr  = fetch_pc_q;
        bus.if_valid       = if_valid_s;
        if (!empty_s) begin
            bus.if_pc          = head_s[2*XLEN-1:XLEN];
            bus.if_instruction = head_s[XLEN-1:0];
        end else if (bypass_s) begin
            bus.if_pc          = resp_pc_q;
            bus.if_instruction = bus.imem_resp_data;
        end else begin
            bus.if_pc          = '0;
            bus.if_instruction = NOP_WORD;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized self-checking bench for fetch_queue against a transaction-level model:
// a queue of outstanding memory requests (with a killed flag) and a queue of buffered PCs.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        bit          killed;
        int          due;
    } req_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    req_t        mem_q[$];
    logic [31:0] out_q[$];
    logic [31:0] exp_fetch_pc;
    int          cyc;
    int          checks_cnt;
    int          errors_cnt;

    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(XLEN)) bus ();

    fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h1234};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit do_reset, input bit redir, input logic [31:0] rpc,
                        input bit rdy, input bit ifr, input int lat_extra, input bit resp_en);
        bit          resp;
        bit          keep;
        bit          byp;
        bit          exp_req_valid;
        bit          exp_if_valid;
        logic [31:0] exp_pc;
        req_t        r;

        @(negedge clk);
        cyc++;
        resp = !do_reset && resp_en && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        reset                = !do_reset;
        redirect_valid       = redir && !do_reset;
        redirect_pc          = rpc;
        bus.imem_req_ready   = rdy;
        bus.if_ready         = ifr;
        bus.imem_resp_valid  = resp;
        bus.imem_resp_data   = resp ? mem_word(mem_q[0].addr) : 32'hDEAD_BEEF;
        #1;

        if (do_reset) begin
            check_eq("req_valid_in_reset", {31'd0, bus.imem_req_valid}, 32'd0);
            mem_q.delete();
            out_q.delete();
            exp_fetch_pc = 32'h0000_0000;
            return;
        end

        byp = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp = resp && !redir && (out_q.size() == 0) && !mem_q[0].killed;
`endif
        exp_req_valid = !redir && ((out_q.size() + mem_q.size()) < DEPTH);
        exp_if_valid  = (out_q.size() > 0) || byp;
        exp_pc        = (out_q.size() > 0) ? out_q[0] : (byp ? mem_q[0].addr : 32'd0);

        check_eq("req_valid", {31'd0, bus.imem_req_valid}, {31'd0, exp_req_valid});
        check_eq("req_addr", bus.imem_req_addr, exp_fetch_pc);
        check_eq("if_valid", {31'd0, bus.if_valid}, {31'd0, exp_if_valid});
        check_eq("if_pc", bus.if_pc, exp_pc);
        check_eq("if_instr", bus.if_instruction, exp_if_valid ? mem_word(exp_pc) : NOP_INSTR);

        keep = 1'b0;
        if (resp) begin
            r    = mem_q.pop_front();
            keep = !redir && !r.killed;
        end
        if (redir) begin
            foreach (mem_q[i]) mem_q[i].killed = 1'b1;
            out_q.delete();
            exp_fetch_pc = {rpc[31:2], 2'b00};
        end else begin
            if ((out_q.size() > 0) && ifr) void'(out_q.pop_front());
            if (keep && !(byp && ifr)) out_q.push_back(r.addr);
            if (exp_req_valid && rdy) begin
                mem_q.push_back('{addr: exp_fetch_pc, killed: 1'b0, due: cyc + 1 + lat_extra});
                exp_fetch_pc = exp_fetch_pc + 32'd4;
            end
        end
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(3, 0))
            0:       return 32'h0000_0100;
            1:       return 32'h0000_0203;
            2:       return 32'hFFFF_FFF8;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        cyc                 = 0;
        checks_cnt          = 0;
        errors_cnt          = 0;
        exp_fetch_pc        = 32'h0000_0000;
        reset               = 1'b0;
        redirect_valid      = 1'b0;
        redirect_pc         = 32'h0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.if_ready        = 1'b0;

        // Streaming with a 1-cycle memory and decode always ready.
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 0, 1'b1);
        repeat (12) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 0, 1'b1);

        // Decode stall fills the credits, then drains.
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 0, 1'b1);
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 0, 1'b1);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 0, 1'b1);

        // Three requests in flight, then redirect to 0x100 and to 0x203 with a response.
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b1, 0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 0, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0203, 1'b1, 1'b1, 0, 1'b1);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 0, 1'b1);

        // PC wrap through 0xFFFF_FFFC -> 0x0.
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 0, 1'b1);
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 0, 1'b1);

        // Reset mid-operation with a full buffer.
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 0, 1'b1);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 0, 1'b1);

        // Randomized traffic with varying decode backpressure.
        for (int i = 0; i < 3000; i++) begin
            automatic int  stall_bias = ((i / 250) % 3) + 1;
            automatic bit  do_rst     = ($urandom_range(199, 0) == 0);
            automatic bit  redir      = ($urandom_range(16, 0) == 0);
            automatic bit  rdy        = ($urandom_range(3, 0) != 0);
            automatic bit  ifr        = ($urandom_range(3, 0) >= stall_bias);
            automatic int  lat        = $urandom_range(2, 0);
            automatic bit  resp_en    = ($urandom_range(4, 0) != 0);
            step(do_rst, redir, pick_target(), rdy, ifr, lat, resp_en);
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
